// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake states, data word and
// the arbiter FSM encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    SNOOP  = 3'd2,
    FLUSH  = 3'd3,
    DREAD  = 3'd4,
    DWRITE = 3'd5,
    IFETCH = 3'd6
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Two-way round-robin grant: a lone requester wins outright; on a tie the
// pointer names the winner.
module rr_picker (
  input  logic [1:0] req_i,
  input  logic       rr_i,
  output logic       grant_o
);

  always_comb begin
    grant_o = 1'b0;
    unique case (req_i)
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = rr_i;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-cache memory arbiter with snoop/flush coherence: one RAM transaction at a
// time, data before instruction, round-robin within a class.
module mem_arbiter
  import cpu_types_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  // instruction side
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0]       iwait,
  output logic [1:0][31:0] iload,
  // data side
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] dload,
  // coherence
  input  logic [1:0]       cctrans,
  input  logic [1:0]       ccwrite,
  output logic [1:0]       ccwait,
  output logic [1:0][31:0] ccsnoopaddr,
  // RAM
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  ramstate_t        ramstate
);

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_q, rr_d;

  logic [1:0] dreq;
  logic       data_pending;
  logic [1:0] pick_req;
  logic       grant;
  logic       other;
  logic       access;

  // A cache raising dREN and dWEN together is a write.
  assign dreq         = dREN | dWEN;
  assign data_pending = |dreq;
  assign pick_req     = data_pending ? dreq : iREN;
  assign other        = ~owner_q;
  assign access       = (ramstate == ACCESS);

  rr_picker u_rr_picker (
    .req_i   (pick_req),
    .rr_i    (rr_q),
    .grant_o (grant)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned and a latch is never inferred.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (|(dreq | iREN)) state_d = ARB;
      end
      ARB: begin
        if (data_pending) begin
          owner_d = grant;
          state_d = dWEN[grant] ? DWRITE : SNOOP;
        end else if (|iREN) begin
          owner_d = grant;
          state_d = IFETCH;
        end else begin
          state_d = IDLE;
        end
      end
      SNOOP: begin
        state_d = (cctrans[other] && ccwrite[other]) ? FLUSH : DREAD;
      end
      FLUSH, DREAD, DWRITE, IFETCH: begin
        // Only ACCESS completes; BUSY, FREE and ERROR all stall.
        if (access) begin
          state_d = IDLE;
          rr_d    = other;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    iwait       = 2'b11;
    dwait       = 2'b11;
    iload       = '0;
    dload       = '0;
    ccwait      = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    // Held quiet while reset is asserted, even before the state register clears.
    if (nRST) begin
      unique case (state_q)
        SNOOP: begin
          ccwait[other]      = 1'b1;
          ccsnoopaddr[other] = daddr[owner_q];
        end
        FLUSH: begin
          // The peer owns a dirty copy: write it back and forward it to the owner.
          ccwait[other]      = 1'b1;
          ccsnoopaddr[other] = daddr[owner_q];
          ramWEN             = 1'b1;
          ramaddr            = daddr[other];
          ramstore           = dstore[other];
          dload[owner_q]     = dstore[other];
          if (access) dwait  = 2'b00;
        end
        DREAD: begin
          ramREN         = 1'b1;
          ramaddr        = daddr[owner_q];
          dload[owner_q] = ramload;
          if (access) dwait[owner_q] = 1'b0;
        end
        DWRITE: begin
          ramWEN             = 1'b1;
          ramaddr            = daddr[owner_q];
          ramstore           = dstore[owner_q];
          ccwait[other]      = 1'b1;
          ccsnoopaddr[other] = daddr[owner_q];
          if (access) dwait[owner_q] = 1'b0;
        end
        IFETCH: begin
          ramREN         = 1'b1;
          ramaddr        = iaddr[owner_q];
          iload[owner_q] = ramload;
          if (access) iwait[owner_q] = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed coherence/arbitration scenarios followed by
// random request batches, all checked against a transaction-level model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
  logic [1:0][31:0] iaddr, daddr, dstore;
  logic [1:0]       iwait, dwait, ccwait;
  logic [1:0][31:0] iload, dload, ccsnoopaddr;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  ramstate_t        ramstate;

  int   total = 0;
  int   bad   = 0;
  logic m_rr;  // model: which cache wins the next tie

  always #5 CLK = ~CLK;

  mem_arbiter dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .iREN        (iREN),
    .iaddr       (iaddr),
    .iwait       (iwait),
    .iload       (iload),
    .dREN        (dREN),
    .dWEN        (dWEN),
    .daddr       (daddr),
    .dstore      (dstore),
    .dwait       (dwait),
    .dload       (dload),
    .cctrans     (cctrans),
    .ccwrite     (ccwrite),
    .ccwait      (ccwait),
    .ccsnoopaddr (ccsnoopaddr),
    .ramREN      (ramREN),
    .ramWEN      (ramWEN),
    .ramaddr     (ramaddr),
    .ramstore    (ramstore),
    .ramload     (ramload),
    .ramstate    (ramstate)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_iwait"}, iwait, 2'b11);
    chk({tag, "_dwait"}, dwait, 2'b11);
    chk({tag, "_ramen"}, {ramREN, ramWEN}, 2'b00);
    chk({tag, "_ccwait"}, ccwait, 2'b00);
  endtask

  task automatic check_reset(input string tag);
    check_quiet(tag);
    chk({tag, "_snpaddr"}, ccsnoopaddr, 64'd0);
    chk({tag, "_ramaddr"}, ramaddr, 32'd0);
    chk({tag, "_ramstore"}, ramstore, 32'd0);
    chk({tag, "_iload"}, iload, 64'd0);
    chk({tag, "_dload"}, dload, 64'd0);
  endtask

  function automatic ramstate_t pick_stall();
    case ($urandom_range(0, 2))
      0:       return BUSY;
      1:       return FREE;
      default: return ERROR;
    endcase
  endfunction

  // Serves every request currently driven until none remain. Called right
  // after a falling edge with the new requests already applied, DUT in IDLE.
  // busy_fix < 0 means a random number of stall cycles per RAM access.
  task automatic run_batch(input int busy_fix, input bit drop_mid);
    logic       w, o, acc, flush;
    logic [1:0] dreq, cand, ew_d, ew_i;
    int         kind;  // 0 write, 1 read, 2 ifetch
    int         nb;
    #1;
    check_quiet("idle");
    while ((iREN | dREN | dWEN) != 2'b00) begin
      dreq = dREN | dWEN;
      cand = (dreq != 2'b00) ? dreq : iREN;
      w    = (cand == 2'b11) ? m_rr : (cand == 2'b10);
      o    = ~w;
      kind = (dreq != 2'b00) ? (dWEN[w] ? 0 : 1) : 2;

      @(negedge CLK); #1;
      check_quiet("arb");

      flush = 1'b0;
      if (kind == 1) begin
        @(negedge CLK);
        if (drop_mid) begin dREN[w] = 1'b0; dWEN[w] = 1'b0; end
        #1;
        chk("snoop_ccwait", ccwait, o ? 2'b10 : 2'b01);
        chk("snoop_addr", ccsnoopaddr[o], daddr[w]);
        chk("snoop_ramen", {ramREN, ramWEN}, 2'b00);
        chk("snoop_dwait", dwait, 2'b11);
        flush = cctrans[o] && ccwrite[o];
      end

      nb = (busy_fix >= 0) ? busy_fix : $urandom_range(0, 3);
      for (int k = 0; k <= nb; k++) begin
        @(negedge CLK);
        if (drop_mid && k == 0) begin
          if (kind == 2) iREN[w] = 1'b0;
          else begin dREN[w] = 1'b0; dWEN[w] = 1'b0; end
        end
        acc      = (k == nb);
        ramstate = acc ? ACCESS : ((busy_fix >= 0) ? BUSY : pick_stall());
        ramload  = $urandom;
        #1;
        ew_d = 2'b11;
        ew_i = 2'b11;
        if (kind == 0) begin
          chk("wr_ramen", {ramREN, ramWEN}, 2'b01);
          chk("wr_addr", ramaddr, daddr[w]);
          chk("wr_data", ramstore, dstore[w]);
          chk("wr_ccwait", ccwait[o], 1'b1);
          chk("wr_snpaddr", ccsnoopaddr[o], daddr[w]);
          if (acc) ew_d[w] = 1'b0;
        end else if (kind == 1 && flush) begin
          chk("fl_ramen", {ramREN, ramWEN}, 2'b01);
          chk("fl_addr", ramaddr, daddr[o]);
          chk("fl_data", ramstore, dstore[o]);
          chk("fl_dload", dload[w], dstore[o]);
          chk("fl_ccwait", ccwait[o], 1'b1);
          if (acc) ew_d = 2'b00;
        end else if (kind == 1) begin
          chk("rd_ramen", {ramREN, ramWEN}, 2'b10);
          chk("rd_addr", ramaddr, daddr[w]);
          chk("rd_dload", dload[w], ramload);
          if (acc) ew_d[w] = 1'b0;
        end else begin
          chk("if_ramen", {ramREN, ramWEN}, 2'b10);
          chk("if_addr", ramaddr, iaddr[w]);
          chk("if_iload", iload[w], ramload);
          if (acc) ew_i[w] = 1'b0;
        end
        chk("ram_dwait", dwait, ew_d);
        chk("ram_iwait", iwait, ew_i);
      end

      @(negedge CLK);
      if (kind == 2) iREN[w] = 1'b0;
      else begin dREN[w] = 1'b0; dWEN[w] = 1'b0; end
      ramstate = FREE;
      m_rr     = o;
      #1;
      check_quiet("idle");
    end
  endtask

  initial begin
    nRST     = 1'b0;
    iREN     = '0; dREN = '0; dWEN = '0;
    cctrans  = '0; ccwrite = '0;
    iaddr    = '0; daddr = '0; dstore = '0;
    ramload  = '0;
    ramstate = FREE;
    m_rr     = 1'b0;

    // Reset held with requests pending: outputs must stay quiet.
    @(negedge CLK);
    iREN = 2'b11; dREN = 2'b11; dWEN = 2'b01;
    repeat (3) begin
      @(negedge CLK); #1;
      check_reset("in_reset");
    end
    @(negedge CLK);
    nRST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0;
    #1;
    check_reset("after_reset");

    // Two data reads at once, pointer 0: cache 0 then cache 1.
    @(negedge CLK);
    dREN = 2'b11; daddr[0] = 32'h100; daddr[1] = 32'h200;
    run_batch(0, 1'b0);

    // Peer holds a dirty copy of 0x40: flush to RAM and forward.
    @(negedge CLK);
    dREN = 2'b01; daddr[0] = 32'h40; daddr[1] = 32'h40; dstore[1] = 32'hDEADBEEF;
    cctrans = 2'b10; ccwrite = 2'b10;
    run_batch(0, 1'b0);
    cctrans = '0; ccwrite = '0;

    // Data write beats instruction fetch.
    @(negedge CLK);
    iREN = 2'b10; iaddr[1] = 32'h500;
    dWEN = 2'b01; daddr[0] = 32'h300; dstore[0] = 32'h1234_5678;
    run_batch(-1, 1'b0);

    // Fetch with four BUSY cycles before ACCESS.
    @(negedge CLK);
    iREN = 2'b01; iaddr[0] = 32'h600;
    run_batch(4, 1'b0);

    // Read and write together from one cache: write only.
    @(negedge CLK);
    dREN = 2'b01; dWEN = 2'b01; daddr[0] = 32'h80; dstore[0] = 32'hCAFE_F00D;
    run_batch(-1, 1'b0);

    // Reset in the middle of a RAM read (pointer is 1 beforehand).
    @(negedge CLK);
    dREN = 2'b01; daddr[0] = 32'h700;
    #1; check_quiet("mid_idle");
    @(negedge CLK); #1;
    @(negedge CLK); #1;
    @(negedge CLK);
    ramstate = BUSY;
    #1;
    chk("mid_dread_ren", ramREN, 1'b1);
    nRST = 1'b0;
    #1;
    chk("mid_rst_ren", ramREN, 1'b0);
    chk("mid_rst_dwait", dwait, 2'b11);
    @(negedge CLK);
    nRST = 1'b1;
    dREN = '0;
    m_rr = 1'b0;
    #1;
    chk("post_rst_ren", ramREN, 1'b0);
    chk("post_rst_dwait", dwait, 2'b11);
    @(negedge CLK); #1;
    check_quiet("post_rst_idle");
    ramstate = FREE;

    // Tie after reset must go to cache 0 again.
    @(negedge CLK);
    dREN = 2'b11; daddr[0] = 32'h900; daddr[1] = 32'hA00;
    run_batch(0, 1'b0);

    // Random batches.
    repeat (40) begin
      @(negedge CLK);
      iREN    = 2'($urandom);
      dREN    = 2'($urandom);
      dWEN    = 2'($urandom);
      cctrans = 2'($urandom);
      ccwrite = 2'($urandom);
      for (int c = 0; c < 2; c++) begin
        iaddr[c]  = $urandom;
        daddr[c]  = $urandom;
        dstore[c] = $urandom;
      end
      run_batch(-1, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
